pwc_step_mac: RTL and testbench

- Downstream consumer of the PWC history stage.
- On each history update it computes the sampled channel output: sum over k of (value_hist[k] - value_hist[k+1]) * step(time_next - time_hist[k]).
- Time-multiplexed multiply-accumulate, one UI per cycle, with a 1-cycle-latency step-response ROM.
- Output feeds the RX comparator/DFE stage.

---
 rtl/pwc_step_mac.sv | 153 +++++++++++++++
 tb/tb_pwc_step_mac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwc_step_mac.sv
// Step-response MAC behind the PWC history stage: one tap per cycle through a
// registered-address step ROM, then a saturated sample to the RX comparator/DFE.
module pwc_step_mac #(
   parameter int NUM_UI      = 4,
   parameter int VALUE_W     = 16,
   parameter int TIME_W      = 16,
   parameter int STEP_ADDR_W = 8,
   parameter int STEP_W      = 16,
   parameter int STEP_POINT  = 14,
   parameter int ACC_W       = 40,
   parameter int OUT_W       = 16
) (
   input  logic                        clk_sys,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [TIME_W-1:0]           time_next,
   input  logic [NUM_UI*VALUE_W-1:0]   value_hist,
   input  logic [NUM_UI*TIME_W-1:0]    time_hist,
   output logic [STEP_ADDR_W-1:0]      step_addr,
   input  logic signed [STEP_W-1:0]    step_data,
   output logic signed [OUT_W-1:0]     out_value,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        out_sat,
   output logic                        overrun
);

   // state   | meaning
   // S_IDLE  | waiting for start; snapshot inputs on start
   // S_ISSUE | drive step_addr for tap k = 0..NUM_UI-1
   // S_DRAIN | ROM data for the last taps still arriving
   // S_DONE  | final tap accumulates; clamp and publish result
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam int IDX_W  = (NUM_UI > 1) ? $clog2(NUM_UI) : 1;
   localparam int PROD_W = VALUE_W + 1 + STEP_W;
   localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

   state_t                     r_state, w_state_nxt;
   logic [TIME_W-1:0]          r_time_next;
   logic [NUM_UI*VALUE_W-1:0]  r_value_hist;
   logic [NUM_UI*TIME_W-1:0]   r_time_hist;
   logic [IDX_W-1:0]           r_idx, r_k1, r_k2;
   logic                       r_v1, r_v2;
   logic [STEP_ADDR_W-1:0]     r_step_addr;
   logic signed [ACC_W-1:0]    r_acc;
   logic signed [OUT_W-1:0]    r_out_value;
   logic                       r_out_valid, r_out_sat, r_overrun;

   logic signed [VALUE_W:0]    w_delta [NUM_UI];
   logic [TIME_W-1:0]          w_time_k;
   logic [STEP_ADDR_W-1:0]     w_addr;
   logic signed [PROD_W-1:0]   w_prod, w_shift;
   logic signed [ACC_W-1:0]    w_term, w_acc_nxt;
   logic                       w_sat_hi, w_sat_lo;
   logic signed [OUT_W-1:0]    w_clamped;

   // The entry past the oldest tap is treated as zero, so the sum telescopes.
   for (genvar g = 0; g < NUM_UI; g++) begin : g_delta
      logic signed [VALUE_W:0] w_cur, w_nxt;
      assign w_cur = {r_value_hist[(g+1)*VALUE_W-1], r_value_hist[g*VALUE_W +: VALUE_W]};
      if (g == NUM_UI-1) begin : g_last
         assign w_nxt = '0;
      end else begin : g_mid
         assign w_nxt = {r_value_hist[(g+2)*VALUE_W-1], r_value_hist[(g+1)*VALUE_W +: VALUE_W]};
      end
      assign w_delta[g] = w_cur - w_nxt;
   end

   assign w_time_k = r_time_hist[r_idx*TIME_W +: TIME_W];
   assign w_addr   = (w_time_k > r_time_next) ? '0
                   : STEP_ADDR_W'((r_time_next - w_time_k) >> (TIME_W - STEP_ADDR_W));

   assign w_prod    = w_delta[r_k2] * step_data;
   assign w_shift   = w_prod >>> STEP_POINT;
   assign w_term    = {{(ACC_W-PROD_W){w_shift[PROD_W-1]}}, w_shift};
   assign w_acc_nxt = r_v2 ? (r_acc + w_term) : r_acc;
   assign w_sat_hi  = (w_acc_nxt > C_MAX);
   assign w_sat_lo  = (w_acc_nxt < C_MIN);
   assign w_clamped = w_sat_hi ? C_MAX[OUT_W-1:0]
                    : w_sat_lo ? C_MIN[OUT_W-1:0]
                    : w_acc_nxt[OUT_W-1:0];

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_ISSUE;
         S_ISSUE: if (r_idx == IDX_W'(NUM_UI-1)) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tap index rides alongside the ROM's address and data stages.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_time_next  <= '0;
         r_value_hist <= '0;
         r_time_hist  <= '0;
         r_idx        <= '0;
         r_k1         <= '0;
         r_k2         <= '0;
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_step_addr  <= '0;
         r_acc        <= '0;
         r_out_value  <= '0;
         r_out_valid  <= 1'b0;
         r_out_sat    <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_v1        <= (r_state == S_ISSUE);
         r_k1        <= r_idx;
         r_v2        <= r_v1;
         r_k2        <= r_k1;
         r_out_valid <= (r_state == S_DONE);
         r_out_sat   <= (r_state == S_DONE) && (w_sat_hi || w_sat_lo);
         if (start && r_state != S_IDLE) r_overrun <= 1'b1;
         if (r_state == S_IDLE && start) begin
            r_time_next  <= time_next;
            r_value_hist <= value_hist;
            r_time_hist  <= time_hist;
         end
         if (r_state == S_ISSUE) begin
            r_idx       <= r_idx + 1'b1;
            r_step_addr <= w_addr;
         end else begin
            r_idx <= '0;
         end
         if (r_state == S_DONE) begin
            r_acc       <= '0;
            r_out_value <= w_clamped;
         end else begin
            r_acc <= w_acc_nxt;
         end
      end
   end

   assign step_addr = r_step_addr;
   assign out_value = r_out_value;
   assign out_valid = r_out_valid;
   assign out_sat   = r_out_sat;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwc_step_mac.sv
// Directed bench for pwc_step_mac: stimulus pushes expected results, a monitor
// pops and compares on every out_valid.
module tb_pwc_step_mac;

   logic               clk_sys = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [15:0]        time_next = '0;
   logic [63:0]        value_hist = '0;
   logic [63:0]        time_hist = '0;
   logic [7:0]         step_addr;
   logic signed [15:0] step_data = '0;
   logic signed [15:0] out_value;
   logic               out_valid, busy, out_sat, overrun;

   pwc_step_mac dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .start     (start),
      .time_next (time_next),
      .value_hist(value_hist),
      .time_hist (time_hist),
      .step_addr (step_addr),
      .step_data (step_data),
      .out_value (out_value),
      .out_valid (out_valid),
      .busy      (busy),
      .out_sat   (out_sat),
      .overrun   (overrun)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // ROM model: mode 0 = constant, mode 1 = 0 at address 0 and 1.0 elsewhere
   int                 rom_mode = 0;
   logic signed [15:0] rom_const = 16'sd16384;
   always @(posedge clk_sys)
      step_data <= (rom_mode == 1) ? ((step_addr == 8'h00) ? 16'sd0 : 16'sd16384) : rom_const;

   typedef struct {
      int val;
      bit sat;
      int cyc;
   } exp_t;
   exp_t sb[$];

   int n_vec  = 0;
   int n_miss = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   always @(negedge clk_sys) begin
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_out_valid: got out_value %0d at cycle %0d, expected no result",
                     out_value, cyc);
         end else begin
            e = sb.pop_front();
            check("out_value", int'(out_value), e.val);
            check("out_sat", int'(out_sat), int'(e.sat));
            check("latency_cycle", cyc, e.cyc);
         end
      end
   end

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic push(input int v, input bit s);
      exp_t e;
      e.val = v;
      e.sat = s;
      e.cyc = cyc + 7;
      sb.push_back(e);
   endtask

   // Pulse start for one cycle, then scramble inputs to prove the snapshot.
   task automatic apply_start(input logic [15:0] tn, input logic [63:0] th, input logic [63:0] vh);
      time_next  = tn;
      time_hist  = th;
      value_hist = vh;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      time_next  = 16'h0123;
      time_hist  = {4{16'hFFFF}};
      value_hist = {4{16'h7ABC}};
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 30) begin
         tick();
         n++;
      end
      if (n >= 30) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_idle_timeout: got busy=%0d pending=%0d, expected idle", busy, sb.size());
      end
      tick();
   endtask

   task automatic run_vec(input string name, input logic [15:0] tn, input logic [63:0] th,
                          input logic [63:0] vh, input int ev, input bit es,
                          input bit chk_addr, input logic [31:0] addrs);
      push(ev, es);
      apply_start(tn, th, vh);
      check({name, "_busy"}, int'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (chk_addr)
            check($sformatf("%s_step_addr%0d", name, k), int'(step_addr), int'(addrs[k*8 +: 8]));
      end
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000 ns, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      check("rst_out_value", int'(out_value), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out_sat", int'(out_sat), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_step_addr", int'(step_addr), 0);
      rst_n = 1'b1;
      tick();

      // telescoping sum with unity ROM
      rom_mode = 0; rom_const = 16'sd16384;
      run_vec("tele", 16'h1000, pk(0, 0, 0, 0), pk(100, 40, -20, 5), 100, 0, 1, 32'h10101010);

      // partial step: tap 0 sees ROM[0] = 0
      rom_mode = 1;
      run_vec("partial", 16'h1000, pk('h1000, 'h0E00, 'h0C00, 'h0A00), pk(100, 40, -20, 5),
              40, 0, 1, 32'h06040200);
      check("addr_hold_idle", int'(step_addr), 'h06);

      // time_hist[0] later than time_next clamps dt to 0
      run_vec("underflow", 16'h1000, pk('h2000, 'h0E00, 'h0C00, 'h0A00), pk(100, 40, -20, 5),
              40, 0, 1, 32'h06040200);

      rom_mode = 0; rom_const = 16'sd32767;
      run_vec("sat_pos", 16'h1000, '0, pk(30000, 0, 0, 0), 32767, 1, 0, '0);
      run_vec("sat_neg", 16'h1000, '0, pk(-30000, 0, 0, 0), -32768, 1, 0, '0);

      // floor rounding of the scaled product (+1.5 -> 1, -1.5 -> -2)
      rom_const = 16'sd8192;
      run_vec("floor_pos", 16'h1000, '0, pk(3, 0, 0, 0), 1, 0, 0, '0);
      run_vec("floor_neg", 16'h1000, '0, pk(-3, 0, 0, 0), -2, 0, 0, '0);

      // full-scale entries: 17-bit delta must not wrap
      rom_const = 16'sd16384;
      run_vec("fullscale", 16'h1000, '0, pk(-32768, 32767, 0, 0), -32768, 0, 0, '0);
      run_vec("maxpos", 16'h1000, '0, pk(32767, 0, 0, 0), 32767, 0, 0, '0);

      // overrun then back-to-back start in the cycle after DONE
      check("pre_overrun", int'(overrun), 0);
      push(100, 0);
      apply_start(16'h1000, '0, pk(100, 40, -20, 5));
      tick();
      apply_start(16'h1000, '0, pk(7, 0, 0, 0));
      check("overrun_set", int'(overrun), 1);
      repeat (4) tick();
      check("idle_after_done", int'(busy), 0);
      push(-50, 0);
      apply_start(16'h1000, '0, pk(-50, 0, 0, 0));
      check("b2b_accepted", int'(busy), 1);
      wait_idle();
      check("overrun_sticky", int'(overrun), 1);

      // reset during ISSUE k=2 aborts with no result
      apply_start(16'h1000, '0, pk(100, 40, -20, 5));
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_out_value", int'(out_value), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_overrun", int'(overrun), 0);
      check("midrst_step_addr", int'(step_addr), 0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      run_vec("after_rst", 16'h1000, pk(0, 0, 0, 0), pk(100, 40, -20, 5), 100, 0, 1, 32'h10101010);

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
